debounce_bank: RTL and testbench

//  Parametrised, multi-channel successor to the single-button debouncer. Each of CHANNELS

---
 rtl/debounce_bank_if.sv | 11 +
 rtl/debounce_bank.sv | 92 +++++++++
 tb/tb_debounce_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: raw button inputs and debounced press/release/level outputs of debounce_bank
interface debounce_bank_if #(
  parameter int CHANNELS = 5
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] level;
  modport master (output btn_in, input press, released, level);
  modport slave (input btn_in, output press, released, level);
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser plus press/release lockout FSM; DEBOUNCE_AUTOREPEAT_EN adds held-button auto-repeat
module debounce_bank #(
  parameter int CHANNELS = 5,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W = 25
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
`endif
) (
  input logic clk,
  input logic reset,
  debounce_bank_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRESS, LOCKP, HELD, RELP, LOCKR} state_t;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(REPEAT_PERIOD - 1);
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q, press_d, rel_q, rel_d, level_q, level_d;
    logic s, rep_fire;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
`endif
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_in[c]};
      state_d = state_q;
      // Counter saturates at 0 and only reloads on PRESS/RELP, so it can never wrap.
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      case (state_q)
        IDLE: state_d = s ? PRESS : IDLE;
        PRESS: begin
          state_d = LOCKP;
          cnt_d = HOLD_M1;
        end
        LOCKP: state_d = (cnt_q != '0) ? LOCKP : s ? HELD : RELP;
        HELD: state_d = s ? HELD : RELP;
        RELP: begin
          state_d = LOCKR;
          cnt_d = HOLD_M1;
        end
        LOCKR: state_d = (cnt_q == '0) ? IDLE : LOCKR;
        default: state_d = IDLE;
      endcase
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_fire = (state_q == HELD) && (state_d == HELD) && (rep_q == '0);
      rep_d = (state_d != HELD) ? '0 :
              (state_q != HELD) ? DELAY_M1 :
              (rep_q == '0) ? PERIOD_M1 : rep_q - 1'b1;
`else
      rep_fire = 1'b0;
`endif
      press_d = (state_d == PRESS) || rep_fire;
      rel_d = (state_d == RELP);
      level_d = (state_d == PRESS) || (state_d == LOCKP) || (state_d == HELD);
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
        state_q <= IDLE;
        cnt_q <= '0;
        press_q <= 1'b0;
        rel_q <= 1'b0;
        level_q <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_q <= '0;
`endif
      end else begin
        sync_q <= sync_d;
        state_q <= state_d;
        cnt_q <= cnt_d;
        press_q <= press_d;
        rel_q <= rel_d;
        level_q <= level_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_q <= rep_d;
`endif
      end
    end
    assign bus.press[c] = press_q;
    assign bus.released[c] = rel_q;
    assign bus.level[c] = level_q;
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed stimulus pushes expected pulse events; a negedge monitor pops and compares them
module tb_debounce_bank;
  localparam int CH = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int base;
  typedef struct {
    int at;
    logic [CH-1:0] p;
    logic [CH-1:0] r;
  } ev_t;
  ev_t exp_q[$];
  debounce_bank_if #(.CHANNELS(CH)) bus ();
  debounce_bank #(
    .CHANNELS(CH),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(8),
    .CNT_W(5)
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_ev(int at, logic [CH-1:0] p, logic [CH-1:0] r);
    ev_t e;
    e.at = at;
    e.p = p;
    e.r = r;
    exp_q.push_back(e);
  endtask
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (cyc > 0 && (bus.press !== '0 || bus.released !== '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse at cycle %0d: press=%b release=%b expected none", cyc, bus.press, bus.released);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.at));
        chk("event_press", 32'(bus.press), 32'(e.p));
        chk("event_release", 32'(bus.released), 32'(e.r));
      end
    end
  end
  initial begin
    bus.btn_in = '1;
    // reset held with all buttons down, then all channels press together
    repeat (3) begin
      step(1);
      chk("reset_press", 32'(bus.press), 32'(0));
      chk("reset_release", 32'(bus.released), 32'(0));
      chk("reset_level", 32'(bus.level), 32'(0));
    end
    reset = 1'b0;
    expect_ev(cyc + 3, 5'b11111, 5'b00000);
    step(12);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b11111);
    step(12);
    // single clean press on channel 0
    bus.btn_in = 5'b00001;
    expect_ev(cyc + 3, 5'b00001, 5'b00000);
    step(10);
    chk("level_held_ch0", 32'(bus.level), 32'(5'b00001));
    step(20);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b00001);
    step(2);
    chk("level_before_release", 32'(bus.level), 32'(5'b00001));
    step(2);
    chk("level_after_release", 32'(bus.level), 32'(0));
    step(8);
    // bouncing press on channel 1
    for (int i = 0; i < 6; i++) begin
      bus.btn_in = (i % 2 == 0) ? 5'b00010 : 5'b00000;
      if (i == 0) expect_ev(cyc + 3, 5'b00010, 5'b00000);
      step(1);
    end
    bus.btn_in = 5'b00010;
    step(14);
    chk("level_bounce_ch1", 32'(bus.level), 32'(5'b00010));
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b00010);
    step(12);
    // simultaneous channels 0 and 4
    bus.btn_in = 5'b10001;
    expect_ev(cyc + 3, 5'b10001, 5'b00000);
    step(20);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b10001);
    step(12);
    // re-press inside the release lockout waits for IDLE
    bus.btn_in = 5'b00100;
    expect_ev(cyc + 3, 5'b00100, 5'b00000);
    step(12);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b00100);
    step(6);
    bus.btn_in = 5'b00100;
    expect_ev(cyc + 7, 5'b00100, 5'b00000);
    step(3);
    chk("level_in_lockr", 32'(bus.level), 32'(0));
    step(16);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b00100);
    step(12);
    // reset during press lockout, button kept held
    bus.btn_in = 5'b01000;
    expect_ev(cyc + 3, 5'b01000, 5'b00000);
    step(6);
    chk("level_in_lockp", 32'(bus.level), 32'(5'b01000));
    reset = 1'b1;
    step(1);
    chk("midreset_press", 32'(bus.press), 32'(0));
    chk("midreset_release", 32'(bus.released), 32'(0));
    chk("midreset_level", 32'(bus.level), 32'(0));
    reset = 1'b0;
    base = cyc + 3;
    expect_ev(base, 5'b01000, 5'b00000);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    expect_ev(base + 29, 5'b01000, 5'b00000);
    expect_ev(base + 34, 5'b01000, 5'b00000);
    expect_ev(base + 39, 5'b01000, 5'b00000);
`endif
    step(44);
    bus.btn_in = '0;
    expect_ev(cyc + 3, 5'b00000, 5'b01000);
    step(17);
    chk("pending_events", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
